// File: rtl/img_proc_engine_if.sv
// Bundle between the image engine and its controller / image memories.
// The engine connects through the slave modport.
interface img_proc_engine_if #(
   parameter int ADDR_W = 6,
   parameter int CH_W   = 8
);
   logic                start;
   logic [1:0]          mode;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   row;
   logic [ADDR_W-1:0]   col;
   logic [3*CH_W-1:0]   in_pix;
   logic                out_we;
   logic [ADDR_W-1:0]   out_row;
   logic [ADDR_W-1:0]   out_col;
   logic [3*CH_W-1:0]   out_pix;

   modport master (
      output start, mode, in_pix,
      input  busy, done, row, col, out_we, out_row, out_col, out_pix
   );

   modport slave (
      input  start, mode, in_pix,
      output busy, done, row, col, out_we, out_row, out_col, out_pix
   );
endinterface

// File: rtl/img_proc_engine.sv
// Streams one operation (row/col mirror, grayscale, 3x3 sharpen) over a
// 2^ADDR_W square image, reading one memory and writing another.
module img_proc_engine #(
   parameter int ADDR_W = 6,
   parameter int CH_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   img_proc_engine_if.slave bus
);
   localparam int PIX_W = 3 * CH_W;
   localparam int ACC_W = CH_W + 5;
   localparam logic [ADDR_W-1:0] MAX_IDX = '1;

   typedef enum logic [2:0] {S_IDLE, S_PIX, S_TAP, S_WR, S_FLUSH, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
   logic [3:0]        tap_q, tap_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
   logic              out_we_q, out_we_d;
   logic [ADDR_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
   logic [PIX_W-1:0]  out_pix_q, out_pix_d;

   logic [ADDR_W-1:0] nxt_r, nxt_c;
   logic              last_pix;
   logic [ACC_W-1:0]  g_ext, contrib, acc_sum;
   logic [CH_W-1:0]   g_sharp;

   // Taps 0..8 walk the 3x3 window row-major starting at (r-1, c-1).
   function automatic logic tap_ok(input logic [ADDR_W-1:0] r, c, input logic [3:0] t);
      logic up, down, left, right;
      up    = (t < 4'd3);
      down  = (t > 4'd5);
      left  = (t == 4'd0) || (t == 4'd3) || (t == 4'd6);
      right = (t == 4'd2) || (t == 4'd5) || (t == 4'd8);
      return !((up && r == '0) || (down && r == MAX_IDX) ||
               (left && c == '0) || (right && c == MAX_IDX));
   endfunction

   // Out-of-bounds taps park the read address on the centre pixel.
   function automatic logic [2*ADDR_W-1:0] tap_rc(input logic [ADDR_W-1:0] r, c,
                                                  input logic [3:0] t);
      logic [ADDR_W-1:0] tr, tc;
      tr = r;
      tc = c;
      if (tap_ok(r, c, t)) begin
         if (t < 4'd3)      tr = r - 1'b1;
         else if (t > 4'd5) tr = r + 1'b1;
         if ((t == 4'd0) || (t == 4'd3) || (t == 4'd6))      tc = c - 1'b1;
         else if ((t == 4'd2) || (t == 4'd5) || (t == 4'd8)) tc = c + 1'b1;
      end
      return {tr, tc};
   endfunction

   function automatic logic [CH_W-1:0] gray(input logic [PIX_W-1:0] p);
      logic [CH_W-1:0] pr, pg, pb, mx, mn;
      logic [CH_W:0]   sum;
      pr  = p[PIX_W-1 -: CH_W];
      pg  = p[2*CH_W-1 -: CH_W];
      pb  = p[CH_W-1:0];
      mx  = (pr > pg) ? pr : pg;
      mx  = (pb > mx) ? pb : mx;
      mn  = (pr < pg) ? pr : pg;
      mn  = (pb < mn) ? pb : mn;
      sum = {1'b0, mx} + {1'b0, mn};
      return sum[CH_W:1];
   endfunction

   always_comb begin
      // NOTE: every *_d gets a default before the case so no path infers a latch.
      state_d   = state_q;
      mode_d    = mode_q;
      r_d       = r_q;
      c_d       = c_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      row_d     = row_q;
      col_d     = col_q;
      out_we_d  = 1'b0;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      out_pix_d = out_pix_q;

      nxt_c    = c_q + 1'b1;
      nxt_r    = (c_q == MAX_IDX) ? r_q + 1'b1 : r_q;
      last_pix = (r_q == MAX_IDX) && (c_q == MAX_IDX);

      // Sharpen arithmetic is two's complement on the G channel only.
      g_ext = {{(ACC_W-CH_W){1'b0}}, bus.in_pix[2*CH_W-1 -: CH_W]};
      if (!tap_ok(r_q, c_q, tap_q)) contrib = '0;
      else if (tap_q == 4'd4)       contrib = (g_ext << 3) + g_ext;
      else                          contrib = -g_ext;
      acc_sum = acc_q + contrib;
      g_sharp = acc_sum[ACC_W-1]           ? '0 :
                (|acc_sum[ACC_W-2:CH_W])   ? '1 : acc_sum[CH_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mode_d  = bus.mode;
               r_d     = '0;
               c_d     = '0;
               tap_d   = '0;
               acc_d   = '0;
               row_d   = '0;
               col_d   = '0;
               busy_d  = 1'b1;
               state_d = (bus.mode == 2'd3) ? S_TAP : S_PIX;
            end
         end
         S_PIX: begin
            out_we_d = 1'b1;
            case (mode_q)
               2'd0: begin
                  out_row_d = MAX_IDX - r_q;
                  out_col_d = c_q;
                  out_pix_d = bus.in_pix;
               end
               2'd1: begin
                  out_row_d = r_q;
                  out_col_d = MAX_IDX - c_q;
                  out_pix_d = bus.in_pix;
               end
               default: begin
                  out_row_d = r_q;
                  out_col_d = c_q;
                  out_pix_d = {{CH_W{1'b0}}, gray(bus.in_pix), {CH_W{1'b0}}};
               end
            endcase
            if (last_pix) begin
               state_d = S_FLUSH;
            end else begin
               r_d   = nxt_r;
               c_d   = nxt_c;
               row_d = nxt_r;
               col_d = nxt_c;
            end
         end
         S_TAP: begin
            acc_d = acc_sum;
            if (tap_q == 4'd8) begin
               // Register the write here so out_we is visible during WR.
               out_we_d  = 1'b1;
               out_row_d = r_q;
               out_col_d = c_q;
               out_pix_d = {{CH_W{1'b0}}, g_sharp, {CH_W{1'b0}}};
               tap_d     = '0;
               state_d   = S_WR;
            end else begin
               tap_d          = tap_q + 4'd1;
               {row_d, col_d} = tap_rc(r_q, c_q, tap_q + 4'd1);
            end
         end
         S_WR: begin
            acc_d = '0;
            if (last_pix) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               r_d            = nxt_r;
               c_d            = nxt_c;
               {row_d, col_d} = tap_rc(nxt_r, nxt_c, 4'd0);
               state_d        = S_TAP;
            end
         end
         S_FLUSH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         r_q       <= '0;
         c_q       <= '0;
         tap_q     <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         out_we_q  <= 1'b0;
         out_row_q <= '0;
         out_col_q <= '0;
         out_pix_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q   <= state_d;
         mode_q    <= mode_d;
         r_q       <= r_d;
         c_q       <= c_d;
         tap_q     <= tap_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         row_q     <= row_d;
         col_q     <= col_d;
         out_we_q  <= out_we_d;
         out_row_q <= out_row_d;
         out_col_q <= out_col_d;
         out_pix_q <= out_pix_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.row     = row_q;
   assign bus.col     = col_q;
   assign bus.out_we  = out_we_q;
   assign bus.out_row = out_row_q;
   assign bus.out_col = out_col_q;
   assign bus.out_pix = out_pix_q;
endmodule

// File: doc/img_proc_engine.md
Name: img_proc_engine

Overview:
Parametrised successor to the fixed 64x64 image processing FSM. It runs one selected operation over a square image held in an external input memory and writes the result to a separate output memory. Operations: vertical mirror, horizontal mirror, grayscale, and 3x3 sharpen. A start/busy/done handshake lets the top-level controller sequence operations instead of relying on hard-wired done flags.

Parameters:
ADDR_W, 6, log2 of image side; image is 2^ADDR_W x 2^ADDR_W pixels (N = 2^ADDR_W).
CH_W, 8, bits per colour channel; a pixel is 3*CH_W bits as {R,G,B}.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous reset, active low.
start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
mode  in  2  operation: 0 vertical mirror (row flip), 1 horizontal mirror (col flip), 2 grayscale, 3 sharpen; latched with start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse after the last write.
row  out  ADDR_W  input memory read row.
col  out  ADDR_W  input memory read column.
in_pix  in  3*CH_W  input memory data; combinational, valid in the same cycle as row/col.
out_we  out  1  output memory write enable.
out_row  out  ADDR_W  output memory write row.
out_col  out  ADDR_W  output memory write column.
out_pix  out  3*CH_W  output memory write data.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. busy=0, done=0, out_we=0, row=col=out_row=out_col=0, out_pix=0, all counters 0. Reset mid-operation aborts it; no further writes occur.
- All outputs are registered. States: IDLE, PIX (mirror/gray streaming), TAP (sharpen neighbour fetch), WR (sharpen write), FLUSH, DONE.
- IDLE: on start=1, latch mode, clear the scan counter (r,c)=(0,0), set busy. Go to PIX if mode<3, else TAP. start while busy is ignored.
- Scan order: row-major. c increments first; wraps N-1 to 0 with r+1.
- PIX: one pixel per cycle. row/col=(r,c) are driven. The captured result is written the next cycle (out_we=1). Output address:
  - mode 0: (N-1-r, c)
  - mode 1: (r, N-1-c)
  - mode 2: (r, c)
- Grayscale: G = (max(R,G,B) + min(R,G,B)) >> 1, computed at CH_W+1 bits with no overflow. R=B=0.
- After (N-1,N-1) is read, go to FLUSH. FLUSH issues the final write, then DONE. Mirror/gray total: N*N+1 write cycles, and done rises N*N+2 cycles after start.
- TAP: 9 cycles per pixel in fixed order (r-1,c-1), (r-1,c), (r-1,c+1), (r,c-1), (r,c), (r,c+1), (r+1,c-1), (r+1,c), (r+1,c+1).
  - An out-of-bounds tap still takes its cycle. It contributes 0, and row/col hold (r,c) for that cycle (no wrap-around reads).
  - Accumulate on the G channel only, signed, width CH_W+5: acc = 9*center - sum(neighbours).
- WR: out_we=1 at (r,c). G = clamp(acc, 0, 2^CH_W-1); R=B=0. Then advance the scan: to TAP, or to DONE after (N-1,N-1). Cost is 10 cycles per pixel.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- out_we is 0 in every cycle not listed above. out_pix, out_row and out_col hold their last values when out_we=0.

Test Plan:
- ADDR_W=2, mode 0, input pix(r,c)={r,c,8'h5A} -> 16 writes where out(3-r,c)={r,c,5A}; done exactly 18 cycles after start; busy high for 17 cycles.
- ADDR_W=2, mode 1, same image -> out(r,3-c)={r,c,5A}; no write ever addresses a row other than r.
- mode 2, pixels {200,50,100}, {0,0,0}, {255,255,255}, {10,255,3} -> G = 125, 0, 255, 129 respectively; R=B=0.
- mode 3, ADDR_W=2, all G=10 -> corner G=60 (90-30), edge G=40 (90-50), interior G=10. Then all G=0 except centre (1,1)=255 -> (1,1)=255 and its neighbours clamp to 0. Confirm there are 10 cycles between successive writes.
- Deassert rst_n for one cycle at write 5 of mode 0 -> out_we=0 and busy=0 from the next cycle, no done pulse. A fresh start restarts from (0,0).
- start pulsed during busy and in the DONE cycle -> ignored: mode unchanged and write count exactly N*N.
